// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// The decoder renames destinations at issue, the dispatcher reads operands
// combinationally, and ROB commits write values back and retire rename state.
// Optional feature macro: RENAME_REGFILE_COMMIT_BYPASS_EN. When it is defined,
// a commit that retires a register being read is forwarded to the read port
// in the same cycle.
module rename_regfile #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             ID_valid,
    input  logic [REG_W-1:0] ID_dest_reg,
    input  logic [TAG_W-1:0] ID_tag,
    input  logic [REG_W-1:0] dispatch_reg1,
    input  logic [REG_W-1:0] dispatch_reg2,
    output logic             dispatch_reg1_busy,
    output logic [TAG_W-1:0] dispatch_reg1_tag,
    output logic [XLEN-1:0]  dispatch_reg1_data,
    output logic             dispatch_reg2_busy,
    output logic [TAG_W-1:0] dispatch_reg2_tag,
    output logic [XLEN-1:0]  dispatch_reg2_data,
    input  logic             CDB_valid,
    input  logic [REG_W-1:0] CDB_reg_dest,
    input  logic [TAG_W-1:0] CDB_tag,
    input  logic [XLEN-1:0]  CDB_data,
    output logic [REG_W:0]   busy_count
);

    localparam int RD_W = 1 + TAG_W + XLEN;

    // Architectural state; entry 0 is held at zero and never updated.
    logic [REG_NUM-1:0]            r_busy;
    logic [REG_NUM-1:0][TAG_W-1:0] r_tag;
    logic [REG_NUM-1:0][XLEN-1:0]  r_data;
    logic [REG_W:0]                r_busy_count;

    logic [REG_NUM-1:0]            w_busy_nxt;
    logic [REG_NUM-1:0][TAG_W-1:0] w_tag_nxt;
    logic [REG_NUM-1:0][XLEN-1:0]  w_data_nxt;
    logic [RD_W-1:0]               w_rd1;
    logic [RD_W-1:0]               w_rd2;

    // Number of set bits in the busy vector.
    function automatic logic [REG_W:0] popcount(input logic [REG_NUM-1:0] vec);
        logic [REG_W:0] cnt;
        cnt = {(REG_W+1){1'b0}};
        for (int i = 0; i < REG_NUM; i++) begin
            cnt = cnt + {{REG_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Read one entry as {busy, tag, data}; x0 reads all zeros, idle regs report tag 0.
    function automatic logic [RD_W-1:0] read_entry(
        input logic [REG_W-1:0]            idx,
        input logic [REG_NUM-1:0]          busy_v,
        input logic [REG_NUM-1:0][TAG_W-1:0] tag_v,
        input logic [REG_NUM-1:0][XLEN-1:0]  data_v
    );
        logic [RD_W-1:0] res;
        res = {RD_W{1'b0}};
        if (idx == {REG_W{1'b0}}) begin
            res = {RD_W{1'b0}};
        end else if (busy_v[idx]) begin
            res = {1'b1, tag_v[idx], data_v[idx]};
        end else begin
            res = {1'b0, {TAG_W{1'b0}}, data_v[idx]};
        end
        return res;
    endfunction

    // Next-state: clear beats rename, rename beats a commit's busy release, commit always writes data.
    always_comb begin
        w_busy_nxt = r_busy;
        w_tag_nxt  = r_tag;
        w_data_nxt = r_data;
        for (int i = 1; i < REG_NUM; i++) begin
            if (CDB_valid && (CDB_reg_dest == REG_W'(i))) begin
                w_data_nxt[i] = CDB_data;
            end else begin
                w_data_nxt[i] = r_data[i];
            end
            if (clear) begin
                w_busy_nxt[i] = 1'b0;
            end else if (ID_valid && (ID_dest_reg == REG_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
                w_tag_nxt[i]  = ID_tag;
            end else if (CDB_valid && (CDB_reg_dest == REG_W'(i)) &&
                         r_busy[i] && (r_tag[i] == CDB_tag)) begin
                w_busy_nxt[i] = 1'b0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
            end
        end
        w_busy_nxt[0] = 1'b0;
        w_tag_nxt[0]  = {TAG_W{1'b0}};
        w_data_nxt[0] = {XLEN{1'b0}};
    end

    // State register: async reset, updates only while rdy is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= {REG_NUM{1'b0}};
            r_tag        <= '0;
            r_data       <= '0;
            r_busy_count <= {(REG_W+1){1'b0}};
        end else if (rdy) begin
            r_busy       <= w_busy_nxt;
            r_tag        <= w_tag_nxt;
            r_data       <= w_data_nxt;
            r_busy_count <= popcount(w_busy_nxt);
        end else begin
            r_busy       <= r_busy;
            r_tag        <= r_tag;
            r_data       <= r_data;
            r_busy_count <= r_busy_count;
        end
    end

    // Combinational operand reads from pre-edge state, with optional commit forwarding.
    always_comb begin
        w_rd1 = read_entry(dispatch_reg1, r_busy, r_tag, r_data);
        w_rd2 = read_entry(dispatch_reg2, r_busy, r_tag, r_data);
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
        // The reader is older than any same-cycle rename, so it sees the committed value.
        if (CDB_valid && (dispatch_reg1 != {REG_W{1'b0}}) && (CDB_reg_dest == dispatch_reg1) &&
            r_busy[dispatch_reg1] && (r_tag[dispatch_reg1] == CDB_tag)) begin
            w_rd1 = {1'b0, {TAG_W{1'b0}}, CDB_data};
        end else begin
            w_rd1 = w_rd1;
        end
        if (CDB_valid && (dispatch_reg2 != {REG_W{1'b0}}) && (CDB_reg_dest == dispatch_reg2) &&
            r_busy[dispatch_reg2] && (r_tag[dispatch_reg2] == CDB_tag)) begin
            w_rd2 = {1'b0, {TAG_W{1'b0}}, CDB_data};
        end else begin
            w_rd2 = w_rd2;
        end
`endif
    end

    assign {dispatch_reg1_busy, dispatch_reg1_tag, dispatch_reg1_data} = w_rd1;
    assign {dispatch_reg2_busy, dispatch_reg2_tag, dispatch_reg2_data} = w_rd2;
    assign busy_count = r_busy_count;

endmodule
